cacheline_adaptor: RTL and testbench

- Sits directly below the cache's data array and moves whole cache lines between it and main memory.
- Converts a single line-wide read or write request from the cache controller into a fixed-length burst of narrower beats on the memory bus.
- Assembles returning beats into a full line. That line, with an all-ones byte write enable, is written into the data array.

---
 rtl/cacheline_adaptor.sv | 131 +++++++++++++
 tb/tb_cacheline_adaptor.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cacheline_adaptor.sv
// cacheline_adaptor: bridges a line-wide cache data array and a narrower
// burst-oriented memory bus. A read request becomes a burst of beats that are
// assembled into a full line. A write request shifts the buffered line out one
// beat per memory acknowledge.
module cacheline_adaptor #(
  parameter int s_offset = 5,  // log2 of bytes per cache line
  parameter int s_burst  = 64  // memory beat width in bits
) (
  input  logic                         clk,
  input  logic                         rst,

  // Cache side
  input  logic [8*(2**s_offset)-1:0]   line_i,
  output logic [8*(2**s_offset)-1:0]   line_o,
  input  logic [31:0]                  address_i,
  input  logic                         read_i,
  input  logic                         write_i,
  output logic                         resp_o,

  // Memory side
  input  logic [s_burst-1:0]           burst_i,
  output logic [s_burst-1:0]           burst_o,
  output logic [31:0]                  address_o,
  output logic                         read_o,
  output logic                         write_o,
  input  logic                         resp_i
);

  // Line geometry. s_burst must divide the line, and the beat count must be a
  // power of two, so the counter spans exactly one burst.
  localparam int S_LINE = 8 * (2 ** s_offset);
  localparam int BEATS  = S_LINE / s_burst;
  localparam int CNT_W  = (BEATS > 1) ? $clog2(BEATS) : 1;

  localparam logic [CNT_W-1:0] LAST_BEAT  = CNT_W'(BEATS - 1);
  localparam logic [31:0]      ALIGN_MASK = ~32'((2 ** s_offset) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;      // beats transferred so far in this burst
  logic [S_LINE-1:0] line_q;     // fill line under assembly / last fill
  logic [S_LINE-1:0] wbuf_q;     // write-back line, beat 0 at the bottom
  logic [31:0]       address_q;  // line-aligned memory address
  logic              read_q;
  logic              write_q;
  logic              resp_q;

  // Control FSM: accepts a request in IDLE (read wins over write), steps one
  // beat per memory acknowledge, then pulses resp_o for a single cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      // NOTE: the wide line and write buffers are reset too, because every
      // output (including line_o and burst_o) must read zero out of reset.
      line_q    <= '0;
      wbuf_q    <= '0;
      address_q <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      resp_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every register samples
      // the pre-edge values and the order of statements does not matter.
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (read_i) begin
            address_q <= address_i & ALIGN_MASK;
            read_q    <= 1'b1;
            state_q   <= READ;
          end else if (write_i) begin
            address_q <= address_i & ALIGN_MASK;
            wbuf_q    <= line_i;
            write_q   <= 1'b1;
            state_q   <= WRITE;
          end
        end

        READ: begin
          if (resp_i) begin
            line_q[s_burst*int'(cnt_q) +: s_burst] <= burst_i;
            cnt_q <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              read_q  <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end

        WRITE: begin
          if (resp_i) begin
            // The next beat moves to the bottom of the buffer so burst_o is
            // always a plain slice with no read-side multiplexer.
            wbuf_q <= wbuf_q >> s_burst;
            cnt_q  <= cnt_q + CNT_W'(1);
            if (cnt_q == LAST_BEAT) begin
              write_q <= 1'b0;
              resp_q  <= 1'b1;
              state_q <= DONE;
            end
          end
        end

        DONE: begin
          resp_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign line_o    = line_q;
  assign burst_o   = wbuf_q[s_burst-1:0];
  assign address_o = address_q;
  assign read_o    = read_q;
  assign write_o   = write_q;
  assign resp_o    = resp_q;

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Testbench for cacheline_adaptor: a transaction-level model predicts every
// output each cycle; directed scenarios pin the model to literal values, then
// randomized requests with random wait states run against the model.
module tb_cacheline_adaptor;

  localparam int S_OFFSET = 5;
  localparam int S_BURST  = 64;
  localparam int S_LINE   = 256;
  localparam int BEATS    = 4;

  localparam int M_IDLE = 0;
  localparam int M_RD   = 1;
  localparam int M_WR   = 2;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [S_LINE-1:0]  line_i = '0;
  logic [S_LINE-1:0]  line_o;
  logic [31:0]        address_i = '0;
  logic               read_i = 1'b0;
  logic               write_i = 1'b0;
  logic               resp_o;
  logic [S_BURST-1:0] burst_i = '0;
  logic [S_BURST-1:0] burst_o;
  logic [31:0]        address_o;
  logic               read_o;
  logic               write_o;
  logic               resp_i = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;
  int n_resp   = 0;

  cacheline_adaptor #(.s_offset(S_OFFSET), .s_burst(S_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .line_i    (line_i),
    .line_o    (line_o),
    .address_i (address_i),
    .read_i    (read_i),
    .write_i   (write_i),
    .resp_o    (resp_o),
    .burst_i   (burst_i),
    .burst_o   (burst_o),
    .address_o (address_o),
    .read_o    (read_o),
    .write_o   (write_o),
    .resp_i    (resp_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [S_LINE-1:0] act,
                       input logic [S_LINE-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A request is either idle, a read burst or a write burst; m_beat counts
  // transferred beats 0..BEATS, and m_resp marks the completion cycle.
  int                 m_kind = M_IDLE;
  int                 m_beat = 0;
  bit                 m_resp = 1'b0;
  logic [31:0]        m_addr = '0;
  logic [S_BURST-1:0] m_line  [BEATS] = '{default: '0};
  logic [S_BURST-1:0] m_wline [BEATS] = '{default: '0};

  function automatic logic [S_LINE-1:0] m_line_packed();
    logic [S_LINE-1:0] v;
    v = '0;
    for (int i = 0; i < BEATS; i++) v[i*S_BURST +: S_BURST] = m_line[i];
    return v;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_kind = M_IDLE;
      m_beat = 0;
      m_resp = 1'b0;
      m_addr = '0;
      for (int i = 0; i < BEATS; i++) begin
        m_line[i]  = '0;
        m_wline[i] = '0;
      end
    end else if (m_resp) begin
      m_resp = 1'b0;
    end else if (m_kind == M_IDLE) begin
      if (read_i || write_i) begin
        m_addr = (address_i / (2 ** S_OFFSET)) * (2 ** S_OFFSET);
        m_beat = 0;
        m_kind = read_i ? M_RD : M_WR;
        if (!read_i)
          for (int i = 0; i < BEATS; i++) m_wline[i] = line_i[i*S_BURST +: S_BURST];
      end
    end else if (resp_i) begin
      if (m_kind == M_RD) m_line[m_beat] = burst_i;
      m_beat = m_beat + 1;
      if (m_beat == BEATS) begin
        m_kind = M_IDLE;
        m_resp = 1'b1;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (rst) begin
      check("rst_line_o", line_o, '0);
      check("rst_burst_o", burst_o, '0);
      check("rst_address_o", address_o, '0);
      check("rst_read_o", read_o, 1'b0);
      check("rst_write_o", write_o, 1'b0);
      check("rst_resp_o", resp_o, 1'b0);
    end else begin
      check("read_o", read_o, m_kind == M_RD);
      check("write_o", write_o, m_kind == M_WR);
      check("resp_o", resp_o, m_resp);
      check("address_o", address_o, m_addr);
      check("line_o", line_o, m_line_packed());
      if (m_kind == M_WR) check("burst_o", burst_o, m_wline[m_beat]);
    end
  end

  always @(negedge clk) if (!rst && resp_o) n_resp++;

  // ---------------- memory responder ----------------
  bit                 resp_pat [$];  // forced resp_i sequence while busy
  logic [S_BURST-1:0] data_q   [$];  // forced read data for accepted beats
  logic [S_BURST-1:0] wlog     [$];  // write beats seen on acknowledge

  always @(negedge clk) begin
    if (read_o || write_o) begin
      if (resp_pat.size() > 0) resp_i = resp_pat.pop_front();
      else                     resp_i = ($urandom_range(0, 3) != 0);
    end else begin
      resp_i = $urandom_range(0, 1) != 0;  // must be ignored when idle
    end
    if (read_o && resp_i && data_q.size() > 0) burst_i = data_q.pop_front();
    else                                       burst_i = {$urandom, $urandom};
    if (write_o && resp_i) wlog.push_back(burst_o);
  end

  // ---------------- controller side ----------------
  task automatic wait_resp(output int busy, output bit saw_rd, output bit saw_wr,
                           output bit ok);
    busy = 0; saw_rd = 1'b0; saw_wr = 1'b0; ok = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (resp_o) begin
        ok = 1'b1;
        break;
      end
      if (read_o)  saw_rd = 1'b1;
      if (write_o) saw_wr = 1'b1;
      if (read_o || write_o) busy++;
    end
  endtask

  initial begin
    int busy;
    bit srd, swr, ok;
    int kind;
    int resp_before;
    bit                 pat7   [7]     = '{1, 0, 0, 1, 1, 0, 1};
    logic [S_BURST-1:0] fill_a [BEATS] = '{64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222,
                                           64'h3333_3333_3333_3333, 64'h4444_4444_4444_4444};
    logic [S_BURST-1:0] fill_b [BEATS] = '{64'h5555_5555_5555_5555, 64'h6666_6666_6666_6666,
                                           64'h7777_7777_7777_7777, 64'h8888_8888_8888_8888};
    logic [S_BURST-1:0] fill_c [BEATS] = '{64'h0101_0101_0101_0101, 64'h0202_0202_0202_0202,
                                           64'h0303_0303_0303_0303, 64'h0404_0404_0404_0404};
    logic [S_BURST-1:0] exp_w  [BEATS] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'hBBBB_BBBB_BBBB_BBBB,
                                           64'hCCCC_CCCC_CCCC_CCCC, 64'hDDDD_DDDD_DDDD_DDDD};

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Read fill, no wait states
    foreach (fill_a[i]) data_q.push_back(fill_a[i]);
    for (int i = 0; i < BEATS; i++) resp_pat.push_back(1'b1);
    address_i = 32'h0000_1234;
    read_i    = 1'b1;
    wait_resp(busy, srd, swr, ok);
    read_i = 1'b0;
    check("fill_resp", ok, 1'b1);
    check("fill_busy_cycles", busy, 4);
    check("fill_saw_read", srd, 1'b1);
    check("fill_no_write", swr, 1'b0);
    check("fill_address", address_o, 32'h0000_1220);
    check("fill_line", line_o,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Write-back, no wait states
    wlog.delete();
    for (int i = 0; i < BEATS; i++) resp_pat.push_back(1'b1);
    line_i    = 256'hDDDDDDDDDDDDDDDD_CCCCCCCCCCCCCCCC_BBBBBBBBBBBBBBBB_AAAAAAAAAAAAAAAA;
    address_i = 32'h0000_8047;
    write_i   = 1'b1;
    wait_resp(busy, srd, swr, ok);
    write_i = 1'b0;
    check("wb_resp", ok, 1'b1);
    check("wb_busy_cycles", busy, 4);
    check("wb_address", address_o, 32'h0000_8040);
    check("wb_beats", wlog.size(), BEATS);
    for (int i = 0; i < BEATS; i++) check("wb_beat_value", wlog[i], exp_w[i]);
    check("wb_line_o_kept", line_o,
          256'h4444444444444444_3333333333333333_2222222222222222_1111111111111111);

    // Read with wait states 1,0,0,1,1,0,1
    foreach (fill_b[i]) data_q.push_back(fill_b[i]);
    foreach (pat7[i])   resp_pat.push_back(pat7[i]);
    address_i = 32'h0000_0FFF;
    read_i    = 1'b1;
    wait_resp(busy, srd, swr, ok);
    read_i = 1'b0;
    check("wait_resp", ok, 1'b1);
    check("wait_busy_cycles", busy, 7);
    check("wait_address", address_o, 32'h0000_0FE0);
    check("wait_line", line_o,
          256'h8888888888888888_7777777777777777_6666666666666666_5555555555555555);

    // Simultaneous read and write: read first, then the held write
    wlog.delete();
    for (int i = 0; i < 8; i++) line_i[i*32 +: 32] = $urandom;
    address_i = 32'h0000_0040;
    read_i    = 1'b1;
    write_i   = 1'b1;
    wait_resp(busy, srd, swr, ok);
    read_i = 1'b0;
    check("both_first_resp", ok, 1'b1);
    check("both_first_is_read", srd, 1'b1);
    check("both_first_no_write", swr, 1'b0);
    wait_resp(busy, srd, swr, ok);
    write_i = 1'b0;
    check("both_second_resp", ok, 1'b1);
    check("both_second_is_write", swr, 1'b1);
    check("both_second_no_read", srd, 1'b0);
    check("both_wr_beats", wlog.size(), BEATS);
    for (int i = 0; i < BEATS; i++)
      check("both_wr_beat_value", wlog[i], line_i[i*S_BURST +: S_BURST]);

    // Reset after two read beats
    resp_pat.push_back(1'b1);
    resp_pat.push_back(1'b1);
    for (int i = 0; i < 6; i++) resp_pat.push_back(1'b0);
    address_i = 32'h0000_2000;
    read_i    = 1'b1;
    repeat (4) @(negedge clk);
    resp_before = n_resp;
    #2 rst = 1'b1;
    #1;
    check("mid_rst_line_o", line_o, '0);
    check("mid_rst_burst_o", burst_o, '0);
    check("mid_rst_address_o", address_o, '0);
    check("mid_rst_read_o", read_o, 1'b0);
    check("mid_rst_write_o", write_o, 1'b0);
    check("mid_rst_resp_o", resp_o, 1'b0);
    read_i = 1'b0;
    resp_pat.delete();
    data_q.delete();
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("no_resp_after_rst", n_resp, resp_before);

    foreach (fill_c[i]) data_q.push_back(fill_c[i]);
    for (int i = 0; i < BEATS; i++) resp_pat.push_back(1'b1);
    read_i = 1'b1;
    wait_resp(busy, srd, swr, ok);
    read_i = 1'b0;
    check("post_rst_resp", ok, 1'b1);
    check("post_rst_address", address_o, 32'h0000_2000);
    check("post_rst_line", line_o,
          256'h0404040404040404_0303030303030303_0202020202020202_0101010101010101);

    // Randomized requests with random wait states
    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 2);
      address_i = $urandom;
      for (int i = 0; i < 8; i++) line_i[i*32 +: 32] = $urandom;
      wlog.delete();
      read_i  = (kind != 1);
      write_i = (kind != 0);
      wait_resp(busy, srd, swr, ok);
      check("rand_resp", ok, 1'b1);
      read_i = 1'b0;
      if (kind == 2) begin
        wait_resp(busy, srd, swr, ok);
        check("rand_resp_second", ok, 1'b1);
      end
      write_i = 1'b0;
      if (kind != 0) begin
        check("rand_wr_beats", wlog.size(), BEATS);
        for (int i = 0; i < BEATS; i++)
          check("rand_wr_beat_value", wlog[i], line_i[i*S_BURST +: S_BURST]);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
